// File: rtl/fechadura_pkg.sv
// Shared lock types: the keypad digit buffer, special key codes and the entry-controller states.
package fechadura_pkg;

  localparam int unsigned NDIG_DEFAULT = 20;

  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;
  localparam logic [3:0] KEY_EMPTY = 4'hF;

  typedef struct packed {
    logic [4*NDIG_DEFAULT-1:0] digits;
  } senhaPac_t;

  typedef enum logic [1:0] {IDLE, ENTRY, FLUSH} digctrl_state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

endpackage

// File: rtl/digitos_ctrl_if.sv
// Keypad-side and consumer-side signals of the digit-entry controller.
interface digitos_ctrl_if;
  import fechadura_pkg::*;

  logic       teclado_en;
  logic       setup_on;
  logic [3:0] key_code;
  logic       key_valid;

  senhaPac_t  digitos_value;
  logic       valid_op;
  logic       valid_setup;
  logic       bip_key;
  logic       key_drop;
  logic [4:0] dig_count;

  modport master (
    output teclado_en, setup_on, key_code, key_valid,
    input  digitos_value, valid_op, valid_setup, bip_key, key_drop, dig_count
  );

  modport slave (
    input  teclado_en, setup_on, key_code, key_valid,
    output digitos_value, valid_op, valid_setup, bip_key, key_drop, dig_count
  );

endinterface

// File: rtl/digitos_timer.sv
// Inactivity counter: synchronous clear, enable, and a sticky terminal-count flag (never wraps).
module digitos_timer #(
  parameter int unsigned TIMEOUT_CYC = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digitos_ctrl.sv
// Keypad-entry controller: shifts accepted keys into the shared buffer and strobes exactly one
// consumer (operacional or setup); flushes on '*'/'#', inactivity timeout and owner change.
module digitos_ctrl
  import fechadura_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 5_000_000,
  parameter int unsigned NDIG        = NDIG_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  digitos_ctrl_if.slave bus
);

  localparam logic [4:0] CNT_MAX = 5'(NDIG);

  digctrl_state_t      state_q, state_d;
  logic                owner_q, owner_d;
  logic [4*NDIG-1:0]   digits_q, digits_d;
  logic [4:0]          count_q, count_d;
  logic                valid_op_q, valid_op_d;
  logic                valid_setup_q, valid_setup_d;
  logic                bip_q, bip_d;
  logic                drop_q, drop_d;
  logic                armed_q;
  logic                accept, is_end, owner_chg;
  logic                tmr_clr, tmr_en, tmr_tc;

  // armed_q keeps a key strobed in the reset-release cycle from being taken.
  assign accept = bus.key_valid && bus.teclado_en && (bus.key_code <= KEY_HASH) &&
                  (state_q != FLUSH) && armed_q;
  assign is_end    = (bus.key_code == KEY_STAR) || (bus.key_code == KEY_HASH);
  assign owner_chg = (bus.setup_on != owner_q);

  digitos_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    digits_d      = digits_q;
    count_d       = count_q;
    valid_op_d    = accept && !owner_q;
    valid_setup_d = accept && owner_q;
    bip_d         = accept;
    drop_d        = bus.key_valid && !accept;
    tmr_clr       = accept;
    tmr_en        = 1'b0;

    if (accept) begin
      digits_d = {digits_q[4*NDIG-5:0], bus.key_code};
      if (is_digit(bus.key_code) && (count_q != CNT_MAX)) begin
        count_d = count_q + 5'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        // Buffer is empty here, so an owner change just retargets future strobes.
        if (accept) begin
          state_d = ENTRY;
        end else begin
          owner_d = bus.setup_on;
        end
      end
      ENTRY: begin
        tmr_en = 1'b1;
        if (accept) begin
          if (is_end || owner_chg) begin
            state_d = FLUSH;
          end
        end else if (tmr_tc || owner_chg) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        digits_d = '1;
        count_d  = '0;
        tmr_clr  = 1'b1;
        owner_d  = bus.setup_on;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      digits_q      <= '1;
      count_q       <= '0;
      valid_op_q    <= 1'b0;
      valid_setup_q <= 1'b0;
      bip_q         <= 1'b0;
      drop_q        <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      digits_q      <= digits_d;
      count_q       <= count_d;
      valid_op_q    <= valid_op_d;
      valid_setup_q <= valid_setup_d;
      bip_q         <= bip_d;
      drop_q        <= drop_d;
      armed_q       <= 1'b1;
    end
  end

  assign bus.digitos_value.digits = digits_q;
  assign bus.valid_op             = valid_op_q;
  assign bus.valid_setup          = valid_setup_q;
  assign bus.bip_key              = bip_q;
  assign bus.key_drop             = drop_q;
  assign bus.dig_count            = count_q;

endmodule

// File: tb/tb_digitos_ctrl.sv
// Directed bench for digitos_ctrl with a short timeout; expected values are hand-computed.
module tb_digitos_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   both_cnt;
  int   vcnt;

  localparam logic [79:0] ALL1 = {80{1'b1}};

  digitos_ctrl_if bus ();

  digitos_ctrl #(
    .TIMEOUT_CYC (50),
    .NDIG        (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.valid_op && bus.valid_setup) both_cnt++;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Strobe key for one cycle; return {valid_op, valid_setup, bip_key, key_drop} of the next cycle.
  task automatic press(input logic [3:0] code, output logic [3:0] strb);
    @(negedge clk);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    strb = {bus.valid_op, bus.valid_setup, bus.bip_key, bus.key_drop};
  endtask

  function automatic logic [3:0] strobes();
    return {bus.valid_op, bus.valid_setup, bus.bip_key, bus.key_drop};
  endfunction

  initial begin
    logic [3:0]  s;
    logic [79:0] e;
    logic [3:0]  keys [4];
    n_checks = 0;
    n_fail   = 0;
    both_cnt = 0;
    vcnt     = 0;
    keys[0] = 4'h1; keys[1] = 4'h2; keys[2] = 4'h3; keys[3] = 4'h4;

    rst            = 1'b1;
    bus.teclado_en = 1'b1;
    bus.setup_on   = 1'b0;
    bus.key_code   = 4'h0;
    bus.key_valid  = 1'b0;

    @(negedge clk);
    check("rst_digits", bus.digitos_value, ALL1);
    check("rst_count", 80'(bus.dig_count), 80'd0);
    check("rst_strobes", 80'(strobes()), 80'd0);
    @(negedge clk);
    rst = 1'b0;

    // Four digits to operacional
    for (int i = 0; i < 4; i++) begin
      press(keys[i], s);
      check("op_key_strobes", 80'(s), 80'(4'b1010));
    end
    e = ALL1;
    e[15:0] = 16'h1234;
    check("op_digits", bus.digitos_value, e);
    check("op_count", 80'(bus.dig_count), 80'd4);

    // '*' ends entry: valid cycle shows it, then flush
    press(4'hA, s);
    check("star_strobes", 80'(s), 80'(4'b1010));
    check("star_digits", 80'(bus.digitos_value.digits[19:0]), 80'(20'h1234A));
    @(negedge clk);
    check("star_flushed", bus.digitos_value, ALL1);
    check("star_count", 80'(bus.dig_count), 80'd0);

    // Inactivity timeout: edge 50 after the key enters FLUSH, edge 51 clears
    press(4'h7, s);
    check("to_key_strobes", 80'(s), 80'(4'b1010));
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid_op || bus.valid_setup) vcnt++;
    end
    check("to_held", 80'(bus.digitos_value.digits[7:0]), 80'(8'hF7));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.valid_op || bus.valid_setup) vcnt++;
    end
    check("to_flushed", bus.digitos_value, ALL1);
    check("to_no_valid", 80'(vcnt), 80'd0);

    // Key together with owner change goes to the old owner, then flush
    press(4'h5, s);
    check("own_key5", 80'(s), 80'(4'b1010));
    @(negedge clk);
    bus.setup_on  = 1'b1;
    bus.key_code  = 4'h6;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("own_key6", 80'(strobes()), 80'(4'b1010));
    check("own_digits", 80'(bus.digitos_value.digits[7:0]), 80'(8'h56));
    @(negedge clk);
    check("own_flushed", bus.digitos_value, ALL1);
    press(4'h9, s);
    check("own_setup_key", 80'(s), 80'(4'b0110));
    check("own_setup_dig", 80'(bus.digitos_value.digits[7:0]), 80'(8'hF9));
    // Owner change without a key: flush only
    bus.setup_on = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.valid_op || bus.valid_setup) vcnt++;
    end
    check("own_back_flush", bus.digitos_value, ALL1);
    check("own_back_novalid", 80'(vcnt), 80'd0);

    // Saturation with 22 keys of 3
    for (int i = 0; i < 22; i++) press(4'h3, s);
    e = {20{4'h3}};
    check("sat_count", 80'(bus.dig_count), 80'd20);
    check("sat_digits", bus.digitos_value, e);
    bus.teclado_en = 1'b0;
    press(4'h5, s);
    check("dis_drop", 80'(s), 80'(4'b0001));
    check("dis_digits", bus.digitos_value, e);
    bus.teclado_en = 1'b1;
    press(4'hE, s);
    check("bad_drop", 80'(s), 80'(4'b0001));
    check("bad_digits", bus.digitos_value, e);
    check("bad_count", 80'(bus.dig_count), 80'd20);

    // Clear out, then reset mid-entry
    repeat (60) @(negedge clk);
    check("sat_timeout", bus.digitos_value, ALL1);
    press(4'h1, s);
    press(4'h2, s);
    check("mid_count2", 80'(bus.dig_count), 80'd2);
    @(negedge clk);
    bus.key_code  = 4'h3;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #2;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    #1;
    check("mid_rst_digits", bus.digitos_value, ALL1);
    check("mid_rst_count", 80'(bus.dig_count), 80'd0);
    check("mid_rst_strobes", 80'(strobes()), 80'd0);
    @(negedge clk);
    @(negedge clk);
    rst           = 1'b0;
    bus.key_code  = 4'h8;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("rel_no_accept", 80'(strobes() >> 1), 80'd0);
    check("rel_digits", bus.digitos_value, ALL1);
    check("rel_count", 80'(bus.dig_count), 80'd0);
    press(4'h2, s);
    check("post_rst_key", 80'(s), 80'(4'b1010));
    check("post_rst_dig", 80'(bus.digitos_value.digits[7:0]), 80'(8'hF2));

    check("one_owner", 80'(both_cnt), 80'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
